// File: rtl/dl_report_collector_pkg.sv
// Shared types and widths for the deadlock report collector.
package dl_report_collector_pkg;

    localparam int CNT_W   = 8;
    localparam int COUNT_W = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_COLLECT,
        ST_REPORT,
        ST_LATCHED
    } dl_state_e;

endpackage

// File: rtl/dl_report_collector_onehot.sv
// Lowest-set-bit one-hot encoder; yields zero when no bit is set.
module dl_lowest_onehot #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] vec_i,
    output logic [WIDTH-1:0] onehot_o
);

    // Two's-complement trick: x & -x isolates the least significant set bit.
    assign onehot_o = vec_i & (~vec_i + WIDTH'(1));

endmodule

// File: rtl/dl_report_collector.sv
// Collects per-process deadlock flags, confirms a candidate, accumulates the chain and hands one report to the log sink.
// state   | meaning
// IDLE    | waiting for any local deadlock flag
// ARMED   | origin chosen, confirming it persists
// COLLECT | deadlock declared, accumulating participants
// REPORT  | report offered to sink
// LATCHED | report delivered, frozen until reset
module dl_report_collector
    import dl_report_collector_pkg::*;
#(
    parameter int PROC_NUM       = 3,
    parameter int CONFIRM_CYCLES = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [PROC_NUM-1:0] dl_in_vec,
    output logic                dl_detect_out,
    output logic [PROC_NUM-1:0] origin,
    output logic                token_clear,
    output logic [PROC_NUM-1:0] chain_vec,
    output logic [COUNT_W-1:0]  chain_count,
    output logic                report_valid,
    input  logic                report_ready
);

    localparam logic [CNT_W-1:0] CONF = CNT_W'(CONFIRM_CYCLES);

    dl_state_e            state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 detect_q;
    logic [PROC_NUM-1:0]  origin_q;
    logic                 token_clear_q;
    logic [PROC_NUM-1:0]  chain_q;
    logic [COUNT_W-1:0]   count_q;
    logic [COUNT_W-1:0]   count_d;
    logic                 valid_q;
    logic [PROC_NUM-1:0]  lowest;

    dl_lowest_onehot #(.WIDTH(PROC_NUM)) u_lowest (
        .vec_i    (dl_in_vec),
        .onehot_o (lowest)
    );

    always_comb begin
        count_d = '0;
        for (int i = 0; i < PROC_NUM; i++) begin
            count_d = count_d + COUNT_W'(chain_q[i]);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            detect_q      <= 1'b0;
            origin_q      <= '0;
            token_clear_q <= 1'b0;
            chain_q       <= '0;
            count_q       <= '0;
            valid_q       <= 1'b0;
        end else begin
            token_clear_q <= 1'b0;
            count_q       <= count_d;
            case (state_q)
                ST_IDLE: begin
                    if (|dl_in_vec) begin
                        origin_q <= lowest;
                        cnt_q    <= '0;
                        state_q  <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if ((dl_in_vec & origin_q) == '0) begin
                        token_clear_q <= 1'b1;
                        origin_q      <= '0;
                        chain_q       <= '0;
                        cnt_q         <= '0;
                        state_q       <= ST_IDLE;
                    end else if (cnt_q + CNT_W'(1) == CONF) begin
                        detect_q <= 1'b1;
                        chain_q  <= dl_in_vec | origin_q;
                        cnt_q    <= '0;
                        state_q  <= ST_COLLECT;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_COLLECT: begin
                    // The extra cycle after the last OR lets chain_count settle before REPORT.
                    if (cnt_q != CONF) begin
                        chain_q <= chain_q | dl_in_vec;
                        cnt_q   <= cnt_q + CNT_W'(1);
                    end else begin
                        valid_q <= 1'b1;
                        state_q <= ST_REPORT;
                    end
                end
                ST_REPORT: begin
                    if (report_ready) begin
                        valid_q <= 1'b0;
                        state_q <= ST_LATCHED;
                    end
                end
                ST_LATCHED: begin
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign dl_detect_out = detect_q;
    assign origin        = origin_q;
    assign token_clear   = token_clear_q;
    assign chain_vec     = chain_q;
    assign chain_count   = count_q;
    assign report_valid  = valid_q;

endmodule

// File: tb/tb_dl_report_collector.sv
// Directed and randomized checks of dl_report_collector against a cycle-count reference model.
module tb_dl_report_collector;

    localparam int PN = 3;
    localparam int C  = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [PN-1:0] dl_in_vec = '0;
    logic          report_ready = 1'b0;
    logic          dl_detect_out;
    logic [PN-1:0] origin;
    logic          token_clear;
    logic [PN-1:0] chain_vec;
    logic [5:0]    chain_count;
    logic          report_valid;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    dl_report_collector #(.PROC_NUM(PN), .CONFIRM_CYCLES(C)) dut (
        .clock         (clock),
        .reset         (reset),
        .dl_in_vec     (dl_in_vec),
        .dl_detect_out (dl_detect_out),
        .origin        (origin),
        .token_clear   (token_clear),
        .chain_vec     (chain_vec),
        .chain_count   (chain_count),
        .report_valid  (report_valid),
        .report_ready  (report_ready)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    function automatic logic [PN-1:0] lowest_bit(input logic [PN-1:0] v);
        logic [PN-1:0] r;
        r = '0;
        for (int i = 0; i < PN; i++) begin
            if (v[i]) begin
                r[i] = 1'b1;
                return r;
            end
        end
        return r;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_detect"}, dl_detect_out, 0);
        chk({tag, "_origin"}, origin, 0);
        chk({tag, "_tclear"}, token_clear, 0);
        chk({tag, "_chain"}, chain_vec, 0);
        chk({tag, "_count"}, chain_count, 0);
        chk({tag, "_valid"}, report_valid, 0);
    endtask

    task automatic do_reset;
        reset = 1'b0;
        dl_in_vec = '0;
        report_ready = 1'b0;
        #2;
        chk_all_zero("rst");
        repeat (2) @(posedge clock);
        #1;
        chk("rst_hold_tclear", token_clear, 0);
        reset = 1'b1;
    endtask

    // mode 0: hold v0; mode 1: random extra bits; mode 2: ~origin for first collect cycle, else 0
    task automatic do_confirmed(input logic [PN-1:0] v0, input int mode, input int hold, input bit early);
        logic [PN-1:0] org;
        logic [PN-1:0] chain;
        logic [PN-1:0] in;
        org = lowest_bit(v0);
        chain = '0;
        report_ready = early;
        dl_in_vec = v0;
        tick;
        chk("origin_load", origin, org);
        chk("armed_nodetect", dl_detect_out, 0);
        for (int k = 2; k <= C + 1; k++) begin
            in = (mode == 1) ? (org | PN'($urandom)) : v0;
            dl_in_vec = in;
            tick;
            if (k == C + 1) chain = in | org;
            chk("confirm_detect", dl_detect_out, (k == C + 1) ? 1 : 0);
            chk("confirm_tclear", token_clear, 0);
        end
        for (int k = C + 2; k <= 2 * C + 1; k++) begin
            if (mode == 0) in = v0;
            else if (mode == 1) in = PN'($urandom);
            else in = (k == C + 2) ? ~org : '0;
            dl_in_vec = in;
            tick;
            chain = chain | in;
            chk("collect_origin", origin, org);
            chk("collect_detect", dl_detect_out, 1);
            chk("collect_valid", report_valid, 0);
        end
        dl_in_vec = PN'($urandom);
        tick;
        chk("report_valid", report_valid, 1);
        chk("report_chain", chain_vec, chain);
        chk("report_count", chain_count, $countones(chain));
        chk("report_origin", origin, org);
        if (!early) begin
            for (int h = 0; h < hold; h++) begin
                dl_in_vec = PN'($urandom);
                tick;
                chk("hold_valid", report_valid, 1);
                chk("hold_chain", chain_vec, chain);
                chk("hold_count", chain_count, $countones(chain));
            end
            report_ready = 1'b1;
        end
        tick;
        chk("xfer_valid_drop", report_valid, 0);
        report_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            dl_in_vec = (j == 0) ? '0 : PN'($urandom);
            report_ready = $urandom_range(1, 0) == 1;
            tick;
            chk("latched_detect", dl_detect_out, 1);
            chk("latched_origin", origin, org);
            chk("latched_chain", chain_vec, chain);
            chk("latched_count", chain_count, $countones(chain));
            chk("latched_valid", report_valid, 0);
        end
        report_ready = 1'b0;
    endtask

    task automatic do_false_alarm(input logic [PN-1:0] v0, input int drop, input bit rnd, input logic [PN-1:0] nv);
        logic [PN-1:0] org;
        org = lowest_bit(v0);
        dl_in_vec = v0;
        tick;
        chk("fa_origin", origin, org);
        for (int k = 2; k < drop; k++) begin
            dl_in_vec = rnd ? (org | PN'($urandom)) : v0;
            tick;
            chk("fa_armed_tclear", token_clear, 0);
            chk("fa_armed_detect", dl_detect_out, 0);
        end
        dl_in_vec = rnd ? (PN'($urandom) & ~org) : '0;
        tick;
        chk("fa_tclear_pulse", token_clear, 1);
        chk("fa_origin_clr", origin, 0);
        chk("fa_detect", dl_detect_out, 0);
        dl_in_vec = nv;
        tick;
        chk("fa_tclear_end", token_clear, 0);
        chk("fa_next_origin", origin, lowest_bit(nv));
        chk("fa_next_detect", dl_detect_out, 0);
    endtask

    initial begin
        logic [PN-1:0] v;
        do_reset;
        do_confirmed(3'b110, 0, 7, 1'b0);

        do_reset;
        do_false_alarm(3'b001, 3, 1'b0, 3'b000);

        do_reset;
        do_confirmed(3'b100, 2, 0, 1'b0);

        do_reset;
        do_confirmed(3'b111, 0, 0, 1'b1);

        do_reset;
        dl_in_vec = 3'b110;
        for (int k = 1; k <= C + 2; k++) tick;
        chk("pre_rst_detect", dl_detect_out, 1);
        #2;
        reset = 1'b0;
        #1;
        chk_all_zero("async_rst");
        tick;
        chk("async_rst_tclear", token_clear, 0);
        do_reset;
        do_confirmed(3'b001, 0, 2, 1'b0);

        for (int n = 0; n < 8; n++) begin
            v = PN'($urandom_range(7, 1));
            do_reset;
            if ($urandom_range(1, 0) == 1)
                do_confirmed(v, 1, $urandom_range(3, 0), $urandom_range(1, 0) == 1);
            else
                do_false_alarm(v, $urandom_range(C + 1, 2), 1'b1, PN'($urandom));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dl_report_collector.md
DL_REPORT_COLLECTOR -- requirements
Module: dl_report_collector

Interface
REQ-001 SHALL have parameter PROC_NUM, default 3, the number of monitored processes (valid range 2..32).
REQ-002 SHALL have parameter CONFIRM_CYCLES, default 4, the number of cycles a candidate deadlock must persist before it is declared (valid range 1..255).
REQ-003 SHALL have port `clock`  in  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port `reset`  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port dl_in_vec  in  PROC_NUM  per-process local deadlock flags from the detect units.
REQ-006 SHALL have port dl_detect_out  out  1  global deadlock declared; broadcast back to all detect units.
REQ-007 SHALL have port origin  out  PROC_NUM  one-hot selected origin process; all-zero when none.
REQ-008 SHALL have port token_clear  out  1  single-cycle pulse that resets the token circulation in the detect units.
REQ-009 SHALL have port chain_vec  out  PROC_NUM  accumulated set of processes participating in the deadlock.
REQ-010 SHALL have port chain_count  out  6  population count of chain_vec.
REQ-011 SHALL have port report_valid  out  1  the report is available.
REQ-012 SHALL have port report_ready  in  1  the logging sink accepts the report.

Function
REQ-013 SHALL implement an FSM with states IDLE, ARMED, COLLECT, REPORT and LATCHED.
REQ-014 In IDLE with dl_in_vec != 0, the block SHALL load origin with the lowest-index set bit, clear the confirm counter and go to ARMED on the next edge.
REQ-015 In ARMED, each cycle in which (dl_in_vec & origin) != 0 SHALL increment the confirm counter.
REQ-016 In ARMED, when the counter reaches CONFIRM_CYCLES the block SHALL go to COLLECT and register dl_detect_out=1 on the same edge.
REQ-017 In ARMED, if the origin bit is 0 (false alarm), the block SHALL pulse token_clear for exactly one cycle, clear origin and return to IDLE; a new candidate is accepted no earlier than the cycle after the return.
REQ-018 On entry to COLLECT, chain_vec SHALL be loaded with dl_in_vec | origin.
REQ-019 In COLLECT, chain_vec SHALL then OR in dl_in_vec every cycle for CONFIRM_CYCLES cycles before the block goes to REPORT; chain_vec bits are never cleared outside IDLE entry or reset.
REQ-020 In REPORT, report_valid SHALL be 1 with chain_vec and chain_count held stable.
REQ-021 In REPORT, the transfer SHALL occur when report_valid and report_ready are both 1; the FSM then goes to LATCHED and report_valid drops on the next cycle.
REQ-022 If report_ready is held high before REPORT, the transfer SHALL complete in the first REPORT cycle.
REQ-023 LATCHED SHALL be terminal: dl_detect_out=1, origin, chain_vec and chain_count frozen, report_valid=0; it is exited only by reset.
REQ-024 From COLLECT onward, dl_detect_out SHALL remain 1 and origin SHALL remain frozen, regardless of dl_in_vec.
REQ-025 chain_count SHALL be a registered popcount, updated one cycle after chain_vec.
REQ-026 The block SHALL NOT enter REPORT until chain_count reflects the final chain_vec.
REQ-027 If several bits are set on IDLE entry, only the lowest index SHALL become origin.
REQ-028 Bits outside the origin SHALL be ignored in ARMED.
REQ-029 Total latency from first nonzero dl_in_vec (stable) to report_valid SHALL be 2*CONFIRM_CYCLES+2 cycles.

Reset
REQ-030 While reset=0, the FSM SHALL be in IDLE.
REQ-031 While reset=0, all outputs SHALL be 0: dl_detect_out, origin, token_clear, chain_vec, chain_count and report_valid.
REQ-032 While reset=0, all counters SHALL be 0.
REQ-033 Reset asserted mid-operation in any state, including LATCHED, SHALL abort immediately with no token_clear pulse.
REQ-034 After reset deasserts, the first candidate SHALL be sampled on the first rising edge.

Structure
REQ-035 A shared package SHALL hold the FSM state enum, CONFIRM counter width (8) and chain_count width (6).
REQ-036 The block SHALL contain one sub-module, dl_lowest_onehot, a parameterised lowest-set-bit one-hot encoder used for origin selection.
REQ-037 The popcount SHALL be inline.

Verification (PROC_NUM=3, CONFIRM_CYCLES=4)
REQ-038 Hold dl_in_vec=3'b110 -> origin=3'b010 after 1 cycle; dl_detect_out=1 after 5 cycles; report_valid=1 at cycle 10; chain_vec=3'b110, chain_count=2.
REQ-039 dl_in_vec=3'b001 for 2 cycles then 0 -> one token_clear pulse, origin=0, IDLE, dl_detect_out never 1.
REQ-040 Confirmed on 3'b100; during COLLECT drive 3'b011 for one cycle -> chain_vec=3'b111, chain_count=3, origin stays 3'b100.
REQ-041 report_ready low for 7 cycles in REPORT -> report_valid and data held stable for 7 cycles; ready high -> LATCHED; dl_in_vec=0 afterwards leaves dl_detect_out=1.
REQ-042 Assert reset in COLLECT -> all outputs 0 asynchronously, no token_clear; after release, 3'b001 restarts detection normally.
